trace_commit_checker: RTL and testbench
=======================================

Name: trace_commit_checker

Overview:
Synthesizable consumer for the per-instruction commit trace (pc, instr, register write) produced by the multi-cycle CPU. It buffers DUT commit events in a small FIFO and pulls golden trace records over a valid/ready stream. Each DUT record is compared field by field against the matching golden record. It sits beside sccomp_dataflow on the FPGA/sim harness and flags the first divergence, with sticky error capture.

Parameters:
DEPTH, 8, commit FIFO entries (power of 2, ≥2)
CNT_W, 32, width of match counter
TIMEOUT, 1024, cycles a non-empty FIFO may wait for golden data (TRACE_TIMEOUT_EN only)

Ports:
clk_in  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
commit_valid  in  1  DUT retired one instruction this cycle
commit_pc  in  32  pc of retired instruction
commit_instr  in  32  instruction word
commit_wen  in  1  GPR write performed
commit_waddr  in  5  GPR index written
commit_wdata  in  32  GPR value written
gold_valid  in  1  golden record available
gold_ready  out  1  golden record consumed this cycle
gold_pc  in  32  expected pc
gold_instr  in  32  expected instr
gold_wen  in  1  expected write enable
gold_waddr  in  5  expected GPR index
gold_wdata  in  32  expected value
match_count  out  CNT_W  records compared equal
mismatch  out  1  sticky: divergence found
err_field  out  4  sticky {wdata,waddr/wen,instr,pc} mismatch bits, one-hot or multi-hot
err_pc  out  32  commit_pc of first failing record
err_index  out  CNT_W  match_count value at failure
overflow  out  1  sticky: commit arrived with FIFO full
timeout  out  1  sticky: golden stream stalled (0 when feature off)

Behaviour:
- Reset (reset==0 at posedge): FIFO empty, state RUN, all outputs 0, gold_ready 0.
- Normalisation: a write with waddr==0 is treated as wen=0, waddr=0, wdata=0 on both sides.
- Push: commit_valid and FIFO not full → enqueue normalised record. commit_valid with FIFO full and no pop the same cycle → drop, overflow=1, state HALT.
- Push and pop in the same cycle while full is legal and frees a slot: no overflow.
- Pop: gold_ready = (state==RUN) & FIFO non-empty & gold_valid. This is combinational; the handshake completes in that cycle.
- Compare: on pop, pc/instr/wen+waddr/wdata of the FIFO head are checked against gold. wdata is checked only when wen=1.
- Result is registered, one cycle after pop:
  - all equal → match_count+1
  - else → mismatch=1; err_field, err_pc and err_index latched; state HALT.
- States:
  - RUN → HALT on mismatch, overflow or timeout.
  - HALT is terminal until reset. gold_ready stays 0, further commits are ignored, and sticky outputs hold.
- Only the first error is captured. If mismatch and overflow occur in the same cycle, both flags set; err_* comes from the compare.
- match_count saturates at all-ones.
- FIFO pointers wrap modulo DEPTH. A full/empty extra bit distinguishes wrap.
- Reset mid-operation clears all state the same cycle, and buffered records are discarded.
- Golden records arriving with the FIFO empty are not consumed (gold_ready=0).

Optional Feature:
TRACE_TIMEOUT_EN defined:
- A counter increments each cycle in RUN with FIFO non-empty and gold_valid=0.
- It clears on any pop.
- When it reaches TIMEOUT: timeout=1, state HALT.

Not defined:
- No counter logic is present.
- timeout is tied to 0.

Test Plan:
- 3 commits (pc 00400000/04/08) with identical golden records, gold_valid held 1 → match_count=3, mismatch=0, gold_ready pulses once per record.
- Golden record 2 has wdata 0x5 vs DUT 0x6 → mismatch=1, err_field=4'b1000, err_pc=00400004, err_index=1; later records are not consumed.
- DUT writes $0 with wdata 0x1234 while golden has wen=0 → match.
- gold_valid=0 while 9 commits arrive with DEPTH=8 → overflow=1 on the 9th. Same test with a pop in the 9th cycle → no overflow.
- Mismatch latched, then reset low for one cycle → all outputs 0, then the run resumes and matches normally.
- TRACE_TIMEOUT_EN, TIMEOUT=16: 1 commit, gold_valid=0 for 16 cycles → timeout=1. Without the macro: timeout stays 0.

Source files
------------

// File: rtl/trace_commit_checker_if.sv
// Commit-trace and golden-trace bundle for trace_commit_checker.
// master: trace source (DUT + golden feeder); slave: the checker.
interface trace_commit_checker_if;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_instr;
    logic        commit_wen;
    logic [4:0]  commit_waddr;
    logic [31:0] commit_wdata;
    logic        gold_valid;
    logic        gold_ready;
    logic [31:0] gold_pc;
    logic [31:0] gold_instr;
    logic        gold_wen;
    logic [4:0]  gold_waddr;
    logic [31:0] gold_wdata;

    modport master (
        output commit_valid, commit_pc, commit_instr,
        output commit_wen, commit_waddr, commit_wdata,
        output gold_valid, gold_pc, gold_instr,
        output gold_wen, gold_waddr, gold_wdata,
        input  gold_ready
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr,
        input  commit_wen, commit_waddr, commit_wdata,
        input  gold_valid, gold_pc, gold_instr,
        input  gold_wen, gold_waddr, gold_wdata,
        output gold_ready
    );
endinterface

// File: rtl/trace_commit_checker.sv
// Commit-trace checker: buffers DUT commits in a FIFO, pops golden
// records over valid/ready, compares field by field, and latches the
// first divergence (sticky).
// Ports: clk_in, reset (sync, active-low); tr (commit/gold bundle,
// slave side); match_count, mismatch, err_field {wdata,wen/waddr,
// instr,pc}, err_pc, err_index, overflow, timeout.
// Optional: define TRACE_TIMEOUT_EN to enable the golden-stall
// watchdog (TIMEOUT cycles); otherwise timeout is tied to 0.
module trace_commit_checker #(
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk_in,
    input  logic                  reset,
    trace_commit_checker_if.slave tr,
    output logic [CNT_W-1:0]      match_count,
    output logic                  mismatch,
    output logic [3:0]            err_field,
    output logic [31:0]           err_pc,
    output logic [CNT_W-1:0]      err_index,
    output logic                  overflow,
    output logic                  timeout
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rec_t;

    typedef enum logic {RUN, HALT} state_t;

    // Writes to $0 are architecturally invisible: fold them to no-write.
    function automatic rec_t norm(input rec_t r);
        rec_t n;
        n = r;
        if (r.waddr == 5'd0) begin
            n.wen   = 1'b0;
            n.wdata = '0;
        end
        return n;
    endfunction

    state_t      state, state_nxt;
    rec_t        fifo_mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    rec_t        head, dut_in, gold_in;
    logic        empty, full, run;
    logic        push, pop, ovf_evt, mis_evt, tmo_evt, err_pend;
    logic [3:0]  cmp_now, cmp_field;
    logic        cmp_vld;
    logic [31:0] cmp_pc;

    assign dut_in  = norm({tr.commit_pc, tr.commit_instr, tr.commit_wen,
                           tr.commit_waddr, tr.commit_wdata});
    assign gold_in = norm({tr.gold_pc, tr.gold_instr, tr.gold_wen,
                           tr.gold_waddr, tr.gold_wdata});
    assign head    = fifo_mem[rd_ptr[AW-1:0]];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign run   = (state == RUN);

    // A failing result waiting to be applied already stops consumption,
    // so nothing beyond the first bad record is popped.
    assign err_pend   = cmp_vld && (cmp_field != 4'd0);
    assign pop        = run && !empty && tr.gold_valid && !err_pend;
    assign tr.gold_ready = pop;
    assign push       = run && tr.commit_valid && (!full || pop);
    assign ovf_evt    = run && tr.commit_valid && full && !pop;
    assign mis_evt    = run && err_pend;

    assign cmp_now[0] = head.pc != gold_in.pc;
    assign cmp_now[1] = head.instr != gold_in.instr;
    assign cmp_now[2] = (head.wen != gold_in.wen) ||
                        (head.waddr != gold_in.waddr);
    assign cmp_now[3] = head.wen && (head.wdata != gold_in.wdata);

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:  if (mis_evt || ovf_evt || tmo_evt) state_nxt = HALT;
            HALT: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= dut_in;
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cmp_vld     <= 1'b0;
            cmp_field   <= '0;
            cmp_pc      <= '0;
            match_count <= '0;
            mismatch    <= 1'b0;
            err_field   <= '0;
            err_pc      <= '0;
            err_index   <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            cmp_vld <= pop;
            if (pop) begin
                cmp_field <= cmp_now;
                cmp_pc    <= head.pc;
            end
            if (run && cmp_vld) begin
                if (cmp_field == 4'd0) begin
                    if (match_count != '1)
                        match_count <= match_count + CNT_W'(1);
                end else begin
                    mismatch  <= 1'b1;
                    err_field <= cmp_field;
                    err_pc    <= cmp_pc;
                    err_index <= match_count;
                end
            end
            if (ovf_evt) overflow <= 1'b1;
        end
    end

`ifdef TRACE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_inc;

    assign tmo_inc = run && !empty && !tr.gold_valid;
    assign tmo_evt = tmo_inc && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if (pop)          tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_evt)      timeout <= 1'b1;
        end
    end
`else
    assign tmo_evt = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_trace_commit_checker.sv
// Directed bench for trace_commit_checker.
// Hand-computed expectations for match, mismatch, $0, overflow, reset.
module tb_trace_commit_checker;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 16;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    always #5 clk_in = ~clk_in;

    trace_commit_checker_if tr();

    logic [CNT_W-1:0] match_count, err_index;
    logic             mismatch, overflow, timeout;
    logic [3:0]       err_field;
    logic [31:0]      err_pc;

    trace_commit_checker #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .tr(tr),
        .match_count(match_count),
        .mismatch(mismatch),
        .err_field(err_field),
        .err_pc(err_pc),
        .err_index(err_index),
        .overflow(overflow),
        .timeout(timeout)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rec_t;

    rec_t ctab [10];
    rec_t gtab [10];
    int   ngold, gidx, pulses;
    int   n_chk, n_fail;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic fill;
        for (int i = 0; i < 10; i++) begin
            ctab[i].pc    = 32'h0040_0000 + 32'(4 * i);
            ctab[i].instr = 32'h0000_0013 | (32'(i) << 20);
            ctab[i].wen   = 1'b1;
            ctab[i].waddr = 5'(i + 1);
            ctab[i].wdata = 32'(i * 3 + 7);
            gtab[i]       = ctab[i];
        end
    endtask

    task automatic run(input int cbase, input int ncommit,
                       input int ncyc, input bit gv);
        for (int i = 0; i < ncyc; i++) begin
            bit   took;
            rec_t c, g;
            c = ctab[(cbase + i) % 10];
            g = gtab[gidx % 10];
            tr.commit_valid = (i < ncommit);
            tr.commit_pc    = c.pc;
            tr.commit_instr = c.instr;
            tr.commit_wen   = c.wen;
            tr.commit_waddr = c.waddr;
            tr.commit_wdata = c.wdata;
            tr.gold_valid   = gv && (gidx < ngold);
            tr.gold_pc      = g.pc;
            tr.gold_instr   = g.instr;
            tr.gold_wen     = g.wen;
            tr.gold_waddr   = g.waddr;
            tr.gold_wdata   = g.wdata;
            #1;
            took = tr.gold_ready;
            if (took) pulses++;
            tick();
            if (took) gidx++;
        end
        tr.commit_valid = 1'b0;
        tr.gold_valid   = 1'b0;
    endtask

    task automatic do_reset;
        tr.commit_valid = 1'b0;
        tr.gold_valid   = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset  = 1'b1;
        gidx   = 0;
        pulses = 0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        ngold  = 10;
        fill();
        tr.commit_valid = 1'b0;
        tr.commit_pc    = '0;
        tr.commit_instr = '0;
        tr.commit_wen   = 1'b0;
        tr.commit_waddr = '0;
        tr.commit_wdata = '0;
        tr.gold_valid   = 1'b0;
        tr.gold_pc      = '0;
        tr.gold_instr   = '0;
        tr.gold_wen     = 1'b0;
        tr.gold_waddr   = '0;
        tr.gold_wdata   = '0;

        reset = 1'b0;
        tick();
        tick();
        tr.gold_valid = 1'b1;
        #1;
        check("rst_ready", tr.gold_ready, 0);
        check("rst_count", match_count, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_field", err_field, 0);
        check("rst_pc", err_pc, 0);
        check("rst_index", err_index, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", timeout, 0);
        tr.gold_valid = 1'b0;
        reset  = 1'b1;
        gidx   = 0;
        pulses = 0;

        run(0, 0, 3, 1'b1);
        check("empty_no_pop", pulses, 0);

        ngold = 3;
        run(0, 3, 8, 1'b1);
        check("m3_count", match_count, 3);
        check("m3_pulses", pulses, 3);
        check("m3_mismatch", mismatch, 0);

        do_reset();
        gtab[1].wdata = 32'h5;
        ctab[1].wdata = 32'h6;
        run(0, 3, 10, 1'b1);
        check("mm_flag", mismatch, 1);
        check("mm_field", err_field, 4'b1000);
        check("mm_pc", err_pc, 32'h0040_0004);
        check("mm_index", err_index, 1);
        check("mm_count", match_count, 1);
        check("mm_pulses", pulses, 2);

        reset = 1'b0;
        tick();
        check("mrst_count", match_count, 0);
        check("mrst_mismatch", mismatch, 0);
        check("mrst_field", err_field, 0);
        check("mrst_pc", err_pc, 0);
        check("mrst_index", err_index, 0);
        reset  = 1'b1;
        gidx   = 0;
        pulses = 0;
        fill();
        run(0, 3, 8, 1'b1);
        check("resume_count", match_count, 3);
        check("resume_mismatch", mismatch, 0);

        do_reset();
        ctab[0].waddr = 5'd0;
        ctab[0].wdata = 32'h1234;
        gtab[0].wen   = 1'b0;
        gtab[0].waddr = 5'd0;
        gtab[0].wdata = 32'h0;
        ngold = 2;
        run(0, 2, 6, 1'b1);
        check("x0_count", match_count, 2);
        check("x0_mismatch", mismatch, 0);
        fill();

        do_reset();
        ngold = 10;
        run(0, 8, 8, 1'b0);
        check("ovf_at8", overflow, 0);
        run(8, 1, 1, 1'b0);
        check("ovf_at9", overflow, 1);
        check("ovf_mismatch", mismatch, 0);
        run(9, 0, 3, 1'b1);
        check("halt_no_pop", pulses, 0);

        do_reset();
        ngold = 9;
        run(0, 8, 8, 1'b0);
        run(8, 1, 1, 1'b1);
        check("fullpop_pulse", pulses, 1);
        check("fullpop_ovf", overflow, 0);
        run(9, 0, 12, 1'b1);
        check("fullpop_count", match_count, 9);
        check("fullpop_ovf2", overflow, 0);
        check("fullpop_mm", mismatch, 0);

        do_reset();
        run(0, 1, 1, 1'b0);
        run(1, 0, 15, 1'b0);
        check("tmo_before", timeout, 0);
        run(1, 0, 1, 1'b0);
`ifdef TRACE_TIMEOUT_EN
        check("tmo_at16", timeout, 1);
`else
        check("tmo_off", timeout, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
